// File: rtl/rx_phase_downsampler.sv
// rx_phase_downsampler: receive-side phase picker and decimator.
// Consumes an N_OS-times oversampled signed stream. Per-phase magnitude is accumulated
// over a window of 2**NB_WIN symbols. At each window end the strongest phase becomes
// the sampling phase. One sample per symbol is then sliced to a recovered bit.
module rx_phase_downsampler #(
    parameter int unsigned NB_INPUT  = 8,
    parameter int unsigned NBF_INPUT = 7,
    parameter int unsigned N_OS      = 4,
    parameter int unsigned NB_PHASE  = 2,
    parameter int unsigned NB_WIN    = 10
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_en,
    input  logic signed [NB_INPUT-1:0] i_os_data,
    input  logic                       i_phase_override,
    input  logic        [NB_PHASE-1:0] i_phase_manual,
    output logic                       o_bit,
    output logic                       o_valid,
    output logic        [NB_PHASE-1:0] o_phase,
    output logic                       o_locked,
    output logic        [NB_PHASE-1:0] o_control
);

    // A full window of full-scale magnitudes (2**NB_WIN * 2**(NB_INPUT-1)) fits exactly.
    localparam int unsigned NB_ENERGY = NB_INPUT + NB_WIN;

    localparam logic [NB_PHASE-1:0] CntLast = NB_PHASE'(N_OS - 1);
    localparam logic [NB_WIN-1:0]   SymLast = {NB_WIN{1'b1}};

    // Reject parameter sets the counters cannot represent. NBF_INPUT is informational
    // only, because slicing looks at the sign bit alone.
    if (N_OS < 2 || N_OS > (2 ** NB_PHASE) || NBF_INPUT >= NB_INPUT) begin : gen_bad_params
        $error("rx_phase_downsampler: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        StAcq,
        StTrack
    } state_e;

    state_e                 state_q, state_d;
    logic [NB_PHASE-1:0]    cnt_q, cnt_d;
    logic [NB_WIN-1:0]      sym_q, sym_d;
    logic [NB_ENERGY-1:0]   acc_q [N_OS];
    logic [NB_ENERGY-1:0]   acc_d [N_OS];
    logic [NB_PHASE-1:0]    phase_q, phase_d;
    logic                   bit_q, bit_d;
    logic                   valid_q, valid_d;

    logic [NB_INPUT-1:0]    data_u;
    logic [NB_INPUT-1:0]    mag;
    logic [NB_ENERGY-1:0]   acc_sum [N_OS];
    logic [NB_ENERGY-1:0]   best_val;
    logic [NB_PHASE-1:0]    best_idx;
    logic [NB_PHASE-1:0]    sel;
    logic                   cnt_wrap;
    logic                   win_end;

    // Magnitude of the current sample and accumulators as they would look including it.
    // The most negative code maps to 2**(NB_INPUT-1), which is still representable.
    always_comb begin
        data_u = i_os_data;
        mag    = data_u[NB_INPUT-1] ? (~data_u + NB_INPUT'(1)) : data_u;
        for (int i = 0; i < N_OS; i++) begin
            acc_sum[i] = acc_q[i] + ((cnt_q == NB_PHASE'(i)) ? NB_ENERGY'(mag) : '0);
        end
    end

    // Argmax over the updated accumulators. Strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = acc_sum[0];
        for (int i = 1; i < N_OS; i++) begin
            if (acc_sum[i] > best_val) begin
                best_val = acc_sum[i];
                best_idx = NB_PHASE'(i);
            end
        end
    end

    // Next-state logic for counters, accumulators, phase estimate, FSM and slicer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        acc_d   = acc_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        valid_d = 1'b0;

        sel      = i_phase_override ? i_phase_manual : phase_q;
        cnt_wrap = (cnt_q == CntLast);
        win_end  = i_en && cnt_wrap && (sym_q == SymLast);

        if (i_en) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + NB_PHASE'(1);
            if (cnt_wrap) begin
                sym_d = sym_q + NB_WIN'(1);
            end
            acc_d = acc_sum;

            // Uses the phase estimate and state from before this sample. A phase select
            // of N_OS or more never matches cnt, so it silences the output.
            if (cnt_q == sel && (state_q == StTrack || i_phase_override)) begin
                valid_d = 1'b1;
                bit_d   = ~i_os_data[NB_INPUT-1];
            end

            // The window-ending sample counts toward the decision, but it is not
            // carried into the next window.
            if (win_end) begin
                for (int i = 0; i < N_OS; i++) begin
                    acc_d[i] = '0;
                end
                phase_d = best_idx;
                state_d = StTrack;
            end
        end
    end

    // All state, including the acquisition/tracking FSM. Cleared asynchronously.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StAcq;
            cnt_q   <= '0;
            sym_q   <= '0;
            phase_q <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < N_OS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            for (int i = 0; i < N_OS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign o_bit     = bit_q;
    assign o_valid   = valid_q;
    assign o_phase   = phase_q;
    assign o_locked  = (state_q == StTrack);
    assign o_control = cnt_q;

endmodule

// File: tb/tb_rx_phase_downsampler.sv
// Testbench for rx_phase_downsampler with N_OS=4 and an 8-symbol window (NB_WIN=3).
module tb_rx_phase_downsampler;

    localparam int NOS  = 4;
    localparam int WSYM = 8;
    localparam int WLEN = NOS * WSYM;

    logic              clk;
    logic              i_rst_n;
    logic              i_en;
    logic signed [7:0] i_os_data;
    logic              i_phase_override;
    logic        [1:0] i_phase_manual;
    logic              o_bit;
    logic              o_valid;
    logic        [1:0] o_phase;
    logic              o_locked;
    logic        [1:0] o_control;

    rx_phase_downsampler #(
        .NB_INPUT  (8),
        .NBF_INPUT (7),
        .N_OS      (NOS),
        .NB_PHASE  (2),
        .NB_WIN    (3)
    ) dut (
        .clk              (clk),
        .i_rst_n          (i_rst_n),
        .i_en             (i_en),
        .i_os_data        (i_os_data),
        .i_phase_override (i_phase_override),
        .i_phase_manual   (i_phase_manual),
        .o_bit            (o_bit),
        .o_valid          (o_valid),
        .o_phase          (o_phase),
        .o_locked         (o_locked),
        .o_control        (o_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts accepted samples and keeps the raw window contents.
    int   m_n;
    int   m_win[$];
    logic m_valid;
    logic m_bit;
    logic [1:0] m_phase;
    logic m_locked;
    logic [1:0] m_ctrl;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_win.delete();
        m_valid = 1'b0;
        m_bit = 1'b0;
        m_phase = 2'd0;
        m_locked = 1'b0;
        m_ctrl = 2'd0;
    endtask

    task automatic model_step(input logic en, input int d, input logic ovr,
                              input logic [1:0] man);
        int p;
        int sel;
        int sums[NOS];
        int best;
        m_valid = 1'b0;
        if (en) begin
            p   = m_n % NOS;
            sel = ovr ? int'(man) : int'(m_phase);
            if (p == sel && (m_locked || ovr)) begin
                m_valid = 1'b1;
                m_bit   = (d >= 0);
            end
            m_win.push_back(d < 0 ? -d : d);
            m_n++;
            if (m_win.size() == WLEN) begin
                for (int q = 0; q < NOS; q++) sums[q] = 0;
                for (int k = 0; k < WLEN; k++) sums[k % NOS] += m_win[k];
                best = 0;
                for (int q = 1; q < NOS; q++) if (sums[q] > sums[best]) best = q;
                m_phase  = 2'(best);
                m_locked = 1'b1;
                m_win.delete();
            end
            m_ctrl = 2'(m_n % NOS);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("bit", 32'(o_bit), 32'(m_bit));
        chk("phase", 32'(o_phase), 32'(m_phase));
        chk("locked", 32'(o_locked), 32'(m_locked));
        chk("control", 32'(o_control), 32'(m_ctrl));
    endtask

    // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
    task automatic step(input logic en, input int d, input logic ovr, input logic [1:0] man);
        i_en             = en;
        i_os_data        = 8'(d);
        i_phase_override = ovr;
        i_phase_manual   = man;
        model_step(en, d, ovr, man);
        @(posedge clk);
        #1;
        check_model();
        i_en = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n          = 1'b0;
        i_en             = 1'b0;
        i_os_data        = '0;
        i_phase_override = 1'b0;
        i_phase_manual   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        int         data;
        logic       ovr;
        logic [1:0] man;
        logic       exp_valid;
        logic       exp_bit;
        logic [1:0] exp_ctrl;
        logic       exp_locked;
    } vec_t;

    vec_t vecs[10];
    int   pd_data[64];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   d;
        int   bias;
        int   nval;
        logic [63:0] last_t;
        logic en;
        logic ovr;

        vecs[0] = '{1'b1,  10, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[1] = '{1'b1, -20, 1'b1, 2'd3, 1'b0, 1'b0, 2'd2, 1'b0};
        vecs[2] = '{1'b1,  30, 1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 1'b0};
        vecs[3] = '{1'b1,  40, 1'b1, 2'd3, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[4] = '{1'b0,  99, 1'b1, 2'd3, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[5] = '{1'b1,   5, 1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[6] = '{1'b1,   6, 1'b1, 2'd3, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[7] = '{1'b1,   7, 1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
        vecs[8] = '{1'b1,  -8, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[9] = '{1'b1,  -1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b0};

        for (int k = 0; k < 64; k++) begin
            d = ((k % NOS) == 2) ? 100 : 10;
            pd_data[k] = ($urandom_range(0, 1) == 1) ? -d : d;
        end

        // Reset state.
        do_reset();
        chk("rst_bit", 32'(o_bit), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_phase", 32'(o_phase), 0);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_control", 32'(o_control), 0);

        // Override in ACQ: table-driven first samples, then lock at sample 32.
        for (int v = 0; v < 10; v++) begin
            step(vecs[v].en, vecs[v].data, vecs[v].ovr, vecs[v].man);
            chk("tbl_valid", 32'(o_valid), 32'(vecs[v].exp_valid));
            chk("tbl_bit", 32'(o_bit), 32'(vecs[v].exp_bit));
            chk("tbl_control", 32'(o_control), 32'(vecs[v].exp_ctrl));
            chk("tbl_locked", 32'(o_locked), 32'(vecs[v].exp_locked));
        end
        for (int k = 9; k < 32; k++) begin
            step(1'b1, $urandom_range(0, 255) - 128, 1'b1, 2'd3);
            if (k == 30) chk("ovr_locked_31", 32'(o_locked), 0);
        end
        chk("ovr_locked_32", 32'(o_locked), 1);

        // Phase detect with continuous enable.
        do_reset();
        nval = 0;
        last_t = '0;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, pd_data[k], 1'b0, 2'd0);
            if (k == 30) chk("pd_locked_31", 32'(o_locked), 0);
            if (k == 31) begin
                chk("pd_locked", 32'(o_locked), 1);
                chk("pd_phase", 32'(o_phase), 2);
            end
            if (o_valid) begin
                if (nval > 0) chk("pd_spacing", 32'($time - last_t), 40);
                last_t = $time;
                nval++;
            end
        end
        chk("pd_count", 32'(nval), 8);

        // Enable gaps: same stimulus at 50% duty; idle cycles carry junk data.
        do_reset();
        nval = 0;
        last_t = '0;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, pd_data[k], 1'b0, 2'd0);
            if (o_valid) begin
                if (nval > 0) chk("gap_spacing", 32'($time - last_t), 80);
                last_t = $time;
                nval++;
            end
            step(1'b0, $urandom_range(0, 255) - 128, 1'b0, 2'd0);
            if (k == 31) chk("gap_phase", 32'(o_phase), 2);
        end
        chk("gap_count", 32'(nval), 8);

        // Tie: equal energy on every phase resolves to phase 0.
        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, 50, 1'b0, 2'd0);
        chk("tie_phase", 32'(o_phase), 0);
        chk("tie_locked", 32'(o_locked), 1);
        step(1'b1, 50, 1'b0, 2'd0);
        chk("tie_valid", 32'(o_valid), 1);
        chk("tie_bit", 32'(o_bit), 1);
        for (int k = 0; k < 7; k++) step(1'b1, 50, 1'b0, 2'd0);

        // Full scale: -128 everywhere, accumulators must not wrap.
        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, -128, 1'b0, 2'd0);
        chk("fs_phase", 32'(o_phase), 0);
        chk("fs_locked", 32'(o_locked), 1);
        step(1'b1, -128, 1'b0, 2'd0);
        chk("fs_valid", 32'(o_valid), 1);
        chk("fs_bit", 32'(o_bit), 0);
        for (int k = 0; k < 40; k++) step(1'b1, -128, 1'b0, 2'd0);

        // Async reset mid-window after a lock with live outputs.
        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, pd_data[k], 1'b0, 2'd0);
        for (int k = 0; k < 16; k++) step(1'b1, pd_data[32 + k], 1'b0, 2'd0);
        step(1'b1, 77, 1'b1, 2'd0);
        chk("pre_rst_valid", 32'(o_valid), 1);
        chk("pre_rst_phase", 32'(o_phase), 2);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_bit", 32'(o_bit), 0);
        chk("arst_valid", 32'(o_valid), 0);
        chk("arst_phase", 32'(o_phase), 0);
        chk("arst_locked", 32'(o_locked), 0);
        chk("arst_control", 32'(o_control), 0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step(1'b1, pd_data[k], 1'b0, 2'd0);
            if (k == 30) chk("arst_locked_31", 32'(o_locked), 0);
        end
        chk("arst_locked_32", 32'(o_locked), 1);
        chk("arst_phase_32", 32'(o_phase), 2);

        // Randomized traffic against the model, with a drifting dominant phase.
        do_reset();
        bias = 0;
        for (int c = 0; c < 900; c++) begin
            if (c % 150 == 0) bias = $urandom_range(0, NOS - 1);
            en  = ($urandom_range(0, 3) != 0);
            ovr = ($urandom_range(0, 5) == 0);
            d = ((m_n % NOS) == bias) ? $urandom_range(60, 127) : $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 1) d = -d;
            if ($urandom_range(0, 50) == 0) d = -128;
            step(en, d, ovr, 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rx_phase_downsampler.md
# rx_phase_downsampler

Receive-side counterpart of the polyphase transmit pulse-shaping filter. It accepts the oversampled (N_OS samples/symbol) signed stream after the channel and matched filtering. It picks the best sampling phase by comparing per-phase accumulated magnitude over a window of symbols, decimates to one sample per symbol and slices each one to a recovered bit. It sits between the receive filter and the BER checker.

## Interface
- NB_INPUT, 8, input sample width (signed, two's complement)
- NBF_INPUT, 7, input fractional bits (informational; slicing uses the sign only)
- N_OS, 4, oversampling factor; N_OS <= 2**NB_PHASE
- NB_PHASE, 2, phase counter / phase select width
- NB_WIN, 10, log2 of the energy window length in symbols
- NB_ENERGY, NB_INPUT+NB_WIN, accumulator width (derived, do not override)

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  sample strobe; one oversampled sample is consumed per cycle with i_en=1
- i_os_data  in  NB_INPUT  signed oversampled sample
- i_phase_override  in  1  1: use i_phase_manual instead of the estimated phase
- i_phase_manual  in  NB_PHASE  manual sampling phase
- o_bit  out  1  recovered bit (1 = sample >= 0)
- o_valid  out  1  one-cycle strobe qualifying o_bit
- o_phase  out  NB_PHASE  currently estimated best phase
- o_locked  out  1  at least one full window has completed
- o_control  out  NB_PHASE  current oversampling phase counter

## Operation
- Phase counter cnt: advances on i_en, N_OS-1 -> 0 wrap; o_control = cnt. Symbol counter sym (NB_WIN bits) advances when i_en and cnt == N_OS-1.
- Magnitude: mag = |i_os_data| as unsigned NB_INPUT bits; -2^(NB_INPUT-1) maps exactly to 2^(NB_INPUT-1), no saturation.
- Accumulators acc[0..N_OS-1], unsigned NB_ENERGY: on i_en, acc[cnt] += mag. Width guarantees no overflow within a window.
- Window end: i_en, cnt == N_OS-1 and sym == 2**NB_WIN-1. Argmax runs over accumulator values that include the current sample. Ties resolve to the lowest index. The result loads o_phase, and all acc clear to 0; the current sample is not carried into the next window.
- FSM:
  - ACQ: o_locked=0. Moves to TRACK at the first window end.
  - TRACK: o_locked=1. o_phase is re-estimated at every window end. Leaves TRACK only on reset.
- Selected phase sel = i_phase_override ? i_phase_manual : o_phase.
- Decimation: on i_en with cnt == sel and (state == TRACK or i_phase_override), register o_bit = ~i_os_data[NB_INPUT-1] and pulse o_valid. Zero slices to 1.
- In ACQ without override, no o_valid is produced.
- Accumulation and phase estimation always run, whatever the override setting.
- i_en=0 freezes all state; o_valid = 0 in that cycle.
- Override changes take effect on the next i_en sample. A new o_phase takes effect from the i_en sample after the window end.
- i_phase_manual >= N_OS: no output is ever produced (sel never matches).

## Timing
- Reset (async assert, sync release) clears all outputs to 0: o_bit, o_valid, o_phase, o_locked, o_control. It also clears cnt, sym and acc, and sets state = ACQ. Reset mid-window discards the partial window.
- o_bit/o_valid: registered, 1 cycle after the i_en cycle carrying the selected sample.
- o_phase/o_locked: valid 1 cycle after the window-ending i_en cycle.
- o_control: reflects the counter value used for the next i_en sample.
- Steady state: o_valid every N_OS i_en strobes. With continuous i_en, that is every N_OS clocks.

## Test plan
- Phase detect. NB_WIN=3, N_OS=4, continuous i_en. Phase 2 = ±100 (random sign), other phases = ±10.
  - After 32 samples: o_locked=1, o_phase=2.
  - Afterwards: o_valid every 4 clocks, o_bit matching the sign of each phase-2 sample.
- Tie. All samples +50. First window -> o_phase=0, o_locked=1. o_bit=1 on every strobe.
- Override in ACQ. i_phase_override=1, i_phase_manual=3, from reset. o_valid is produced 1 cycle after every cnt=3 sample from the first symbol onward, with o_locked still 0 until sample 32.
- Enable gaps. Same stimulus as phase detect with i_en at 50% duty. Identical o_phase and bit sequence; o_valid spacing 8 clocks; state frozen while i_en=0.
- Full scale. All samples -128, NB_WIN=3. Accumulators reach exactly 1024 with no wrap; o_phase=0; all bits 0.
- Async reset mid-window. Assert i_rst_n=0 after 17 samples. All outputs go to 0 immediately. After release, first lock occurs exactly 32 samples later.
